mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 shift-add multiplier and restoring divider.
// One operation at a time: IDLE -> PREP (magnitudes) -> RUN (WIDTH steps) -> FIX (signs, write-back).
// Optional divide support is controlled by the macro MULT_DIV_UNIT_DIV_EN; when it is
// undefined only multiplies are accepted and div_by_zero is tied low.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             mult_sign,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_count;
    logic               r_aNeg;
    logic               r_bNeg;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               w_accept;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_prod;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic               r_opDiv;
    logic               r_dbz;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divDiff;
    logic               w_divFits;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept    = start & ~flush;
    assign div_by_zero = r_dbz;
`else
    assign w_accept    = start & ~flush & ~op_div;
    assign div_by_zero = 1'b0;
`endif

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Iteration arithmetic and final sign correction, shared by all states.
    always_comb begin
        w_mulSum = {1'b0, r_work} + ({1'b0, r_m} & {(WIDTH+1){r_q[0]}});
        w_prod   = (r_aNeg ^ r_bNeg) ? -{r_work, r_q} : {r_work, r_q};
`ifdef MULT_DIV_UNIT_DIV_EN
        w_divShift = {r_work, r_q[WIDTH-1]};
        w_divDiff  = w_divShift - {1'b0, r_m};
        w_divFits  = ~w_divDiff[WIDTH];
        w_quot     = (r_aNeg ^ r_bNeg) ? -r_q : r_q;
        w_rem      = r_aNeg ? -r_work : r_work;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush overrides everything and forces IDLE.
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_next = PREP;
                PREP: w_next = RUN;
                RUN:  if (r_count == '0) w_next = FIX;
                FIX:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (r_state != IDLE);
    end

    // Datapath: operand capture, magnitude prep, iteration and write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_aNeg  <= 1'b0;
            r_bNeg  <= 1'b0;
            r_m     <= '0;
            r_work  <= '0;
            r_q     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
            r_opDiv <= 1'b0;
            r_dbz   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (!flush) begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_q    <= a;
                            r_m    <= b;
                            r_work <= '0;
                            r_aNeg <= mult_sign & a[WIDTH-1];
                            r_bNeg <= mult_sign & b[WIDTH-1];
`ifdef MULT_DIV_UNIT_DIV_EN
                            r_opDiv <= op_div;
`endif
                        end
                    end
                    PREP: begin
                        if (r_aNeg) r_q <= -r_q;
                        if (r_bNeg) r_m <= -r_m;
                        r_count <= CW'(WIDTH - 1);
                    end
                    RUN: begin
`ifdef MULT_DIV_UNIT_DIV_EN
                        if (r_opDiv) begin
                            r_work <= w_divFits ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0];
                            r_q    <= {r_q[WIDTH-2:0], w_divFits};
                        end else
`endif
                        begin
                            r_work <= w_mulSum[WIDTH:1];
                            r_q    <= {w_mulSum[0], r_q[WIDTH-1:1]};
                        end
                        if (r_count != '0) r_count <= r_count - CW'(1);
                    end
                    FIX: begin
                        r_done <= 1'b1;
`ifdef MULT_DIV_UNIT_DIV_EN
                        if (r_opDiv) begin
                            r_hi  <= w_rem;
                            r_lo  <= (r_m == '0) ? '1 : w_quot;
                            r_dbz <= (r_m == '0);
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                            r_dbz        <= 1'b0;
                        end
`else
                        {r_hi, r_lo} <= w_prod;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven self-checking bench for mult_div_unit (WIDTH=32).
// Expected results are pushed to a scoreboard queue at start and popped on done.
// Divide vectors are checked as real divides with MULT_DIV_UNIT_DIV_EN, and as ignored requests without it.
module tb_mult_div_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic        op_div;
    logic        mult_sign;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       name;
        logic        div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_div      (op_div),
        .mult_sign   (mult_sign),
        .flush       (flush),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void addVec(input string name, input logic div, input logic sgn,
                                   input logic [31:0] va, input logic [31:0] vb,
                                   input logic [31:0] eHi, input logic [31:0] eLo, input logic eDbz);
        vec_t v;
        v.name = name; v.div = div; v.sgn = sgn; v.a = va; v.b = vb;
        v.hi = eHi; v.lo = eLo; v.dbz = eDbz;
        vecs.push_back(v);
    endfunction

    // Drives a one-cycle start request; called at a falling edge, returns at the next one.
    task automatic driveStart(input logic div, input logic sgn, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; op_div = div; mult_sign = sgn; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic div, input logic sgn, input logic [31:0] va, input logic [31:0] vb,
                                 input logic [31:0] eHi, input logic [31:0] eLo, input logic eDbz);
        exp_t e;
        e.hi = eHi; e.lo = eLo; e.dbz = eDbz;
        sb.push_back(e);
        driveStart(div, sgn, va, vb);
    endtask

    // Waits for done with a cycle budget; an expired budget counts as a failure.
    task automatic waitDone(input string name, output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(negedge clk);
            edges++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checkCount++;
            $display("[TB] FAIL %s_timeout: no done within 60 cycles, required done=1", name);
            if (sb.size() > 0) sb.delete(0);
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL %s_scoreboard: queue empty, required one entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_hi"}, 64'(hi), 64'(e.hi));
            check({name, "_lo"}, 64'(lo), 64'(e.lo));
            check({name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
            check({name, "_busyAtDone"}, 64'(busy), 64'(0));
            lastHi = e.hi;
            lastLo = e.lo;
        end
    endtask

    task automatic runOp(input string name, input logic div, input logic sgn, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] eHi, input logic [31:0] eLo, input logic eDbz);
        int edges;
        bit seen;
        applyStimulus(div, sgn, va, vb, eHi, eLo, eDbz);
        waitDone(name, edges, seen);
        if (seen) begin
            check({name, "_latency"}, 64'(edges), 64'(34));
            checkOutput(name);
            @(negedge clk);
            check({name, "_donePulse"}, 64'(done), 64'(0));
        end
    endtask

    // Watches for any busy/done activity over a number of cycles.
    task automatic watchIdle(input string name, input int cycles);
        int active = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy || done) active++;
        end
        check({name, "_idleCycles"}, 64'(active), 64'(0));
        check({name, "_hiKept"}, 64'(hi), 64'(lastHi));
        check({name, "_loKept"}, 64'(lo), 64'(lastLo));
    endtask

`ifndef MULT_DIV_UNIT_DIV_EN
    task automatic checkIgnoredDiv(input string name, input logic sgn, input logic [31:0] va, input logic [31:0] vb);
        driveStart(1'b1, sgn, va, vb);
        check({name, "_busyAfterStart"}, 64'(busy), 64'(0));
        watchIdle(name, 40);
        check({name, "_dbzTied"}, 64'(div_by_zero), 64'(0));
    endtask
`endif

    initial begin
        int          edges;
        bit          seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] p;

        reset = 1'b0; start = 1'b0; op_div = 1'b0; mult_sign = 1'b0; flush = 1'b0; a = '0; b = '0;

        addVec("smul_7xm3",     1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        addVec("umul_max",      1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        addVec("umul_shift",    1'b0, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);
        addVec("smul_m1xm1",    1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
        addVec("smul_minxmin",  1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        addVec("sdiv_m7d2",     1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        addVec("udiv_by0",      1'b1, 1'b0, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
        addVec("sdiv_minDm1",   1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        addVec("udiv_100d7",    1'b1, 1'b0, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0);
        addVec("udiv_maxd16",   1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0);
        addVec("sdiv_7dm2",     1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        addVec("sdiv_m7by0",    1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        addVec("umul_zeroClr",  1'b0, 1'b0, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0);

        // Reset state, held across clock edges.
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_dbz",  64'(div_by_zero), 64'(0));
        check("reset_hi",   64'(hi), 64'(0));
        check("reset_lo",   64'(lo), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].div) begin
`ifdef MULT_DIV_UNIT_DIV_EN
                runOp(vecs[i].name, 1'b1, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
`else
                checkIgnoredDiv(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b);
`endif
            end else begin
                runOp(vecs[i].name, 1'b0, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
            end
        end

        // Random multiplies against a 64-bit reference product.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (rs) p = $signed(ra) * $signed(rb);
            else    p = {32'b0, ra} * {32'b0, rb};
            runOp($sformatf("rmul%0d", i), 1'b0, rs, ra, rb, p[63:32], p[31:0], 1'b0);
        end

        // Start while busy (sampled at edge 5) is ignored and not queued.
        applyStimulus(1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        repeat (4) @(negedge clk);
        driveStart(1'b0, 1'b0, 32'd9, 32'd9);
        check("busyStart_busy", 64'(busy), 64'(1));
        waitDone("busyStart", edges, seen);
        if (seen) begin
            check("busyStart_latency", 64'(edges), 64'(29));
            checkOutput("busyStart");
        end
        watchIdle("busyStart_noQueue", 40);

        // Flush sampled at edge 10: no done, results untouched.
        driveStart(1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFD);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flushMid_busy", 64'(busy), 64'(0));
        watchIdle("flushMid", 40);

        // Flush and start together in IDLE: nothing starts.
        flush = 1'b1;
        driveStart(1'b0, 1'b0, 32'd2, 32'd2);
        flush = 1'b0;
        check("flushStart_busy", 64'(busy), 64'(0));
        watchIdle("flushStart", 40);

        // Reset at edge 20 of an operation clears all outputs at once.
        driveStart(1'b0, 1'b0, 32'd6, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midReset_busy", 64'(busy), 64'(0));
        check("midReset_done", 64'(done), 64'(0));
        check("midReset_dbz",  64'(div_by_zero), 64'(0));
        check("midReset_hi",   64'(hi), 64'(0));
        check("midReset_lo",   64'(lo), 64'(0));
        lastHi = '0;
        lastLo = '0;
        @(negedge clk);
        reset = 1'b1;
        runOp("afterReset", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
